// File: rtl/serial_paralelo_rx_if.sv
// serial_paralelo_rx_if
// Bundles the per-lane receive signals of the serial-to-parallel stage.
//   data_in     serial bit, MSB of each byte first (driven by the line side)
//   data_out    last valid received byte
//   valid_out   data_out holds a byte received in the current byte period
//   byte_strobe one-cycle pulse at each byte boundary while active
//   active      lane aligned and locked
// Modports: master = line/consumer side, slave = deserializer.
interface serial_paralelo_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );
endinterface

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx
// Per-lane receive deserializer. Searches the serial stream for the COM
// symbol to find byte alignment, declares the lane active after LOCK_COUNT
// consecutive aligned COMs, then emits one byte per 8 bit-times. COM and
// IDL fill symbols are reported as invalid once active. Lock is sticky;
// only reset returns the lane to the search state.
// Ports:
//   clk_32f  bit clock, rising edge
//   reset    asynchronous, active-low
//   rx       serial_paralelo_rx_if.slave (data_in in; data_out, valid_out,
//            byte_strobe, active out)
module serial_paralelo_rx #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter logic [7:0]  IDL        = 8'h7C,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    serial_paralelo_rx_if.slave   rx
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t     state_q,       state_d;
    logic [7:0] sr_q,          sr_d;
    logic [2:0] bc_q,          bc_d;
    logic [3:0] cc_q,          cc_d;
    logic [7:0] data_out_q,    data_out_d;
    logic       valid_out_q,   valid_out_d;
    logic       byte_strobe_q, byte_strobe_d;
    logic       active_q,      active_d;

    // Byte completed by the bit arriving on this edge.
    logic [7:0] cand;
    logic       boundary;
    logic [3:0] cc_inc;

    assign cand     = {sr_q[6:0], rx.data_in};
    assign boundary = (bc_q == 3'd7);
    assign cc_inc   = cc_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        sr_d          = cand;
        bc_d          = bc_q;
        cc_d          = cc_q;
        data_out_d    = data_out_q;
        valid_out_d   = valid_out_q;
        byte_strobe_d = 1'b0;
        active_d      = active_q;

        case (state_q)
            SEARCH: begin
                // Bit-by-bit scan; a hit defines the byte phase.
                if (cand == COM) begin
                    bc_d    = 3'd0;
                    cc_d    = 4'd1;
                    state_d = LOCKING;
                end
            end

            LOCKING: begin
                bc_d = bc_q + 3'd1;
                if (boundary) begin
                    if (cand == COM) begin
                        cc_d = cc_inc;
                        if (cc_inc == LOCK_CNT) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // The failed byte is not rescanned; search resumes
                        // with the next incoming bit.
                        cc_d    = 4'd0;
                        state_d = SEARCH;
                    end
                end
            end

            ACTIVE: begin
                bc_d = bc_q + 3'd1;
                if (boundary) begin
                    byte_strobe_d = 1'b1;
                    if ((cand == COM) || (cand == IDL)) begin
                        valid_out_d = 1'b0;
                    end else begin
                        data_out_d  = cand;
                        valid_out_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q       <= SEARCH;
            sr_q          <= 8'h00;
            bc_q          <= 3'd0;
            cc_q          <= 4'd0;
            data_out_q    <= 8'h00;
            valid_out_q   <= 1'b0;
            byte_strobe_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bc_q          <= bc_d;
            cc_q          <= cc_d;
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            byte_strobe_q <= byte_strobe_d;
            active_q      <= active_d;
        end
    end

    assign rx.data_out    = data_out_q;
    assign rx.valid_out   = valid_out_q;
    assign rx.byte_strobe = byte_strobe_q;
    assign rx.active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx
// Directed bench for serial_paralelo_rx: aligned lock, misaligned start,
// failed lock, fill suppression, mid-byte asynchronous reset and a
// pseudo-COM stream. Bits are driven just after a rising edge and outputs
// are sampled 1 time unit after the edge that captured the bit.
module tb_serial_paralelo_rx;

    logic clk_32f;
    logic reset;
    int   n_tests;
    int   n_fail;

    serial_paralelo_rx_if rx_if ();

    serial_paralelo_rx #(
        .COM        (8'hBC),
        .IDL        (8'h7C),
        .LOCK_COUNT (4)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .rx      (rx_if.slave)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_if.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Sends b[hi] down to b[lo], MSB first.
    task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 7, 0);
    endtask

    task automatic do_reset();
        rx_if.data_in = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk_32f);
        #1;
        reset = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},   rx_if.data_out,    8'h00);
        chk({tag, "_valid"},  rx_if.valid_out,   8'h00);
        chk({tag, "_strobe"}, rx_if.byte_strobe, 8'h00);
        chk({tag, "_active"}, rx_if.active,      8'h00);
    endtask

    // Three COMs, then the fourth with a check just before and after its last bit.
    task automatic lock_seq(input string tag);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_bits(8'hBC, 7, 1);
        chk({tag, "_active_pre"}, rx_if.active, 8'h00);
        send_bit(1'b0);
        chk({tag, "_active"}, rx_if.active, 8'h01);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b0;
        rx_if.data_in = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_32f);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;

        // Aligned lock
        lock_seq("align");
        chk("align_strobe_lock", rx_if.byte_strobe, 8'h00);
        chk("align_valid_lock",  rx_if.valid_out,   8'h00);
        send_bits(8'h0E, 7, 1);
        chk("align_strobe_mid0", rx_if.byte_strobe, 8'h00);
        send_bit(1'b0);
        chk("align_data0",   rx_if.data_out,    8'h0E);
        chk("align_valid0",  rx_if.valid_out,   8'h01);
        chk("align_strobe0", rx_if.byte_strobe, 8'h01);
        send_bit(1'b1);
        chk("align_strobe_off", rx_if.byte_strobe, 8'h00);
        chk("align_valid_hold", rx_if.valid_out,   8'h01);
        chk("align_data_hold",  rx_if.data_out,    8'h0E);
        send_bits(8'h8E, 6, 0);
        chk("align_data1",   rx_if.data_out,    8'h8E);
        chk("align_strobe1", rx_if.byte_strobe, 8'h01);

        // Misaligned start
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        lock_seq("misal");
        send_byte(8'hC0);
        chk("misal_data",  rx_if.data_out,  8'hC0);
        chk("misal_valid", rx_if.valid_out, 8'h01);

        // Failed lock
        do_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h55);
        chk("fail_active_55", rx_if.active, 8'h00);
        lock_seq("fail");
        send_byte(8'h4E);
        chk("fail_data",  rx_if.data_out,  8'h4E);
        chk("fail_valid", rx_if.valid_out, 8'h01);

        // Fill suppression
        do_reset();
        lock_seq("fill");
        send_byte(8'h0A);
        chk("fill_data0",  rx_if.data_out,  8'h0A);
        chk("fill_valid0", rx_if.valid_out, 8'h01);
        send_byte(8'hBC);
        chk("fill_valid_com",  rx_if.valid_out,   8'h00);
        chk("fill_data_com",   rx_if.data_out,    8'h0A);
        chk("fill_strobe_com", rx_if.byte_strobe, 8'h01);
        send_byte(8'h7C);
        chk("fill_valid_idl", rx_if.valid_out, 8'h00);
        chk("fill_data_idl",  rx_if.data_out,  8'h0A);
        send_byte(8'h8E);
        chk("fill_data3",  rx_if.data_out,  8'h8E);
        chk("fill_valid3", rx_if.valid_out, 8'h01);

        // Mid-byte asynchronous reset
        send_bits(8'h0E, 7, 4);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b1;
        lock_seq("midrst");
        send_byte(8'h0A);
        chk("midrst_data",  rx_if.data_out,  8'h0A);
        chk("midrst_valid", rx_if.valid_out, 8'h01);

        // Pseudo-COM stream
        do_reset();
        send_byte(8'h5E);
        send_byte(8'h80);
        chk("pseudo_active", rx_if.active, 8'h00);
        lock_seq("pseudo");
        send_byte(8'h11);
        chk("pseudo_data",  rx_if.data_out,  8'h11);
        chk("pseudo_valid", rx_if.valid_out, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
